t03_dpu_pixel_renderer: RTL and testbench

- Downstream consumer of the DPU MMIO register decoder; takes its live game-state, health and position registers.
- Once per frame, copies them into shadow registers so mid-frame MMIO writes never tear the image.
- Answers pixel colour requests from the display driver through a fixed 2-cycle pipeline: health bars, two player sprites, ground, sky.
- Tracks per-player damage flash across frames.

---
 rtl/t03_dpu_pixel_renderer.sv | 159 +++++++++++++++
 tb/tb_t03_dpu_pixel_renderer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/t03_dpu_pixel_renderer.sv
// Pixel colour renderer: frame-latched shadows of MMIO game state, sprite/bar/ground/sky compositing.
// Latency: fixed 2 cycles from pix_req to pix_valid (stage 1 hit flags, stage 2 colour).
// Backpressure: none; accepts one request every cycle and never stalls.
module t03_dpu_pixel_renderer #(
    parameter int SCREEN_W     = 320,
    parameter int GROUND_Y     = 200,
    parameter int SPR_W        = 16,
    parameter int SPR_H        = 32,
    parameter int BAR_H        = 8,
    parameter int BAR_SCALE    = 4,
    parameter int FLASH_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  gameState,
    input  logic [1:0]  p1State,
    input  logic [1:0]  p2State,
    input  logic [4:0]  p1health,
    input  logic [4:0]  p2health,
    input  logic [10:0] x1,
    input  logic [10:0] y1,
    input  logic [10:0] x2,
    input  logic [10:0] y2,
    input  logic        frame_start,
    input  logic        pix_req,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    output logic        pix_valid,
    output logic [15:0] pix_color
);
    localparam int FLW = $clog2(FLASH_FRAMES + 1);

    localparam logic [15:0] C_BLACK  = 16'h0000;
    localparam logic [15:0] C_TITLE  = 16'h0010;
    localparam logic [15:0] C_BAR1   = 16'h07E0;
    localparam logic [15:0] C_BAR2   = 16'h001F;
    localparam logic [15:0] C_GROUND = 16'h8200;
    localparam logic [15:0] C_SKY    = 16'h5D1F;

    typedef enum logic {WAIT_FRAME, ACTIVE} state_t;
    state_t r_state, w_state_nxt;

    logic [1:0]     r_gs, r_p1s, r_p2s;
    logic [4:0]     r_p1h, r_p2h;
    logic [10:0]    r_x1, r_y1, r_x2, r_y2;
    logic [FLW-1:0] r_fl1, r_fl2;

    logic           r_v1, r_blank, r_title, r_hb1, r_hb2, r_hs1, r_hs2, r_hg;
    logic [15:0]    r_c1, r_c2;

    logic [11:0]    w_px, w_py, w_bar1_len, w_bar2_len;
    logic           w_spr1, w_spr2, w_bar1, w_bar2, w_bars_on, w_draw1, w_draw2;
    logic [15:0]    w_color;

    function automatic logic [15:0] f_spr_color(input logic [1:0] st, input logic [FLW-1:0] fl,
                                                input logic is_p1);
        if (fl != '0 && fl[1])
            return 16'hFFFF;
        case (st)
            2'b00:   return is_p1 ? 16'hFFE0 : 16'hF81F;
            2'b01:   return 16'hF800;
            2'b10:   return 16'h7BEF;
            default: return 16'hFD20;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= WAIT_FRAME;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (frame_start)
            w_state_nxt = ACTIVE;
    end

    // Flash counters compare incoming health against the shadow before it is overwritten.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gs  <= '0;  r_p1s <= '0;  r_p2s <= '0;
            r_p1h <= '0;  r_p2h <= '0;
            r_x1  <= '0;  r_y1  <= '0;  r_x2  <= '0;  r_y2 <= '0;
            r_fl1 <= '0;  r_fl2 <= '0;
        end else if (frame_start) begin
            r_gs  <= gameState;  r_p1s <= p1State;  r_p2s <= p2State;
            r_p1h <= p1health;   r_p2h <= p2health;
            r_x1  <= x1;  r_y1 <= y1;  r_x2 <= x2;  r_y2 <= y2;
            if (p1health < r_p1h)
                r_fl1 <= FLW'(FLASH_FRAMES);
            else if (r_fl1 != '0)
                r_fl1 <= r_fl1 - 1'b1;
            if (p2health < r_p2h)
                r_fl2 <= FLW'(FLASH_FRAMES);
            else if (r_fl2 != '0)
                r_fl2 <= r_fl2 - 1'b1;
        end
    end

    // 12-bit compares so a sprite near x=2047 clips instead of wrapping to column 0.
    assign w_px       = {1'b0, pix_x};
    assign w_py       = {1'b0, pix_y};
    assign w_bar1_len = 12'(r_p1h) * 12'(BAR_SCALE);
    assign w_bar2_len = 12'(r_p2h) * 12'(BAR_SCALE);

    assign w_spr1 = (w_px >= {1'b0, r_x1}) && (w_px < {1'b0, r_x1} + 12'(SPR_W)) &&
                    (w_py >= {1'b0, r_y1}) && (w_py < {1'b0, r_y1} + 12'(SPR_H));
    assign w_spr2 = (w_px >= {1'b0, r_x2}) && (w_px < {1'b0, r_x2} + 12'(SPR_W)) &&
                    (w_py >= {1'b0, r_y2}) && (w_py < {1'b0, r_y2} + 12'(SPR_H));
    assign w_bar1 = (w_py < 12'(BAR_H)) && (w_px >= 12'd4) && (w_px < 12'd4 + w_bar1_len);
    assign w_bar2 = (w_py < 12'(BAR_H)) && (w_px + w_bar2_len >= 12'(SCREEN_W - 4)) &&
                    (w_px < 12'(SCREEN_W - 4));

    assign w_bars_on = (r_gs == 2'b01);
    assign w_draw1   = (r_gs != 2'b11);
    assign w_draw2   = (r_gs != 2'b10);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1 <= 1'b0;  r_blank <= 1'b0;  r_title <= 1'b0;
            r_hb1 <= 1'b0; r_hb2 <= 1'b0;    r_hs1 <= 1'b0;   r_hs2 <= 1'b0;  r_hg <= 1'b0;
            r_c1 <= '0;    r_c2 <= '0;
        end else begin
            r_v1    <= pix_req;
            r_blank <= (r_state == WAIT_FRAME);
            r_title <= (r_gs == 2'b00);
            r_hb1   <= w_bars_on && w_bar1;
            r_hb2   <= w_bars_on && w_bar2;
            r_hs1   <= w_draw1 && w_spr1;
            r_hs2   <= w_draw2 && w_spr2;
            r_hg    <= (w_py >= 12'(GROUND_Y));
            r_c1    <= f_spr_color(r_p1s, r_fl1, 1'b1);
            r_c2    <= f_spr_color(r_p2s, r_fl2, 1'b0);
        end
    end

    always_comb begin
        w_color = C_SKY;
        if (r_blank)     w_color = C_BLACK;
        else if (r_title) w_color = C_TITLE;
        else if (r_hb1)  w_color = C_BAR1;
        else if (r_hb2)  w_color = C_BAR2;
        else if (r_hs1)  w_color = r_c1;
        else if (r_hs2)  w_color = r_c2;
        else if (r_hg)   w_color = C_GROUND;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_valid <= 1'b0;
            pix_color <= '0;
        end else begin
            pix_valid <= r_v1;
            pix_color <= r_v1 ? w_color : C_BLACK;
        end
    end
endmodule

// File: tb/tb_t03_dpu_pixel_renderer.sv
// Randomized + directed bench for t03_dpu_pixel_renderer against a frame-level behavioural model.
module tb_t03_dpu_pixel_renderer;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  gameState, p1State, p2State;
    logic [4:0]  p1health, p2health;
    logic [10:0] x1, y1, x2, y2;
    logic        frame_start, pix_req;
    logic [10:0] pix_x, pix_y;
    logic        pix_valid;
    logic [15:0] pix_color;

    int checks = 0;
    int errors = 0;

    // Model: frame-latched view of the game and the pending (one-step-old) expected result.
    int m_active, m_gs, m_p1s, m_p2s, m_p1h, m_p2h, m_x1, m_y1, m_x2, m_y2, m_fl1, m_fl2;
    int pv_v, pv_c;

    t03_dpu_pixel_renderer dut (
        .clk(clk), .rst(rst), .gameState(gameState), .p1State(p1State), .p2State(p2State),
        .p1health(p1health), .p2health(p2health), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .frame_start(frame_start), .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
        .pix_valid(pix_valid), .pix_color(pix_color)
    );

    always #5 clk = ~clk;

    function automatic int spr_col(int st, int fl, bit is_p1);
        if (fl != 0 && ((fl / 2) % 2) == 1) return 'hFFFF;
        case (st)
            0: return is_p1 ? 'hFFE0 : 'hF81F;
            1: return 'hF800;
            2: return 'h7BEF;
            default: return 'hFD20;
        endcase
    endfunction

    function automatic int model_color(int x, int y);
        if (m_active == 0) return 0;
        if (m_gs == 0) return 'h0010;
        if (m_gs == 1 && y < 8) begin
            if (x >= 4 && x < 4 + m_p1h * 4) return 'h07E0;
            if (x >= 316 - m_p2h * 4 && x < 316) return 'h001F;
        end
        if (m_gs != 3 && x >= m_x1 && x < m_x1 + 16 && y >= m_y1 && y < m_y1 + 32)
            return spr_col(m_p1s, m_fl1, 1'b1);
        if (m_gs != 2 && x >= m_x2 && x < m_x2 + 16 && y >= m_y2 && y < m_y2 + 32)
            return spr_col(m_p2s, m_fl2, 1'b0);
        if (y >= 200) return 'h8200;
        return 'h5D1F;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_gs = 0; m_p1s = 0; m_p2s = 0; m_p1h = 0; m_p2h = 0;
        m_x1 = 0; m_y1 = 0; m_x2 = 0; m_y2 = 0; m_fl1 = 0; m_fl2 = 0;
        pv_v = 0; pv_c = 0;
    endtask

    // One clock: predict this cycle's request, apply frame latch, then check last cycle's request.
    task automatic step();
        int v, c;
        v = int'(pix_req);
        c = model_color(int'(pix_x), int'(pix_y));
        if (frame_start) begin
            if (int'(p1health) < m_p1h) m_fl1 = 8; else if (m_fl1 > 0) m_fl1--;
            if (int'(p2health) < m_p2h) m_fl2 = 8; else if (m_fl2 > 0) m_fl2--;
            m_gs = gameState; m_p1s = p1State; m_p2s = p2State;
            m_p1h = p1health; m_p2h = p2health;
            m_x1 = x1; m_y1 = y1; m_x2 = x2; m_y2 = y2;
            m_active = 1;
        end
        @(posedge clk);
        #1;
        chk("pix_valid", pix_valid, pv_v);
        if (pv_v != 0) chk("pix_color", pix_color, pv_c);
        pv_v = v;
        pv_c = c;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic req(int x, int y);
        pix_req = 1'b1;
        pix_x = 11'(x);
        pix_y = 11'(y);
        step();
        pix_req = 1'b0;
    endtask

    task automatic req_chk(string tag, int x, int y, int exp);
        req(x, y);
        step();
        chk(tag, pix_color, exp);
    endtask

    initial begin
        int cnt, nvalid, rx, ry;
        rst = 1'b0;
        gameState = 0; p1State = 0; p2State = 0; p1health = 0; p2health = 0;
        x1 = 0; y1 = 0; x2 = 0; y2 = 0;
        frame_start = 0; pix_req = 0; pix_x = 0; pix_y = 0;
        model_reset();
        #12;
        chk("reset_valid", pix_valid, 1'b0);
        chk("reset_color", pix_color, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        req_chk("wait_frame_black", 0, 0, 'h0000);

        gameState = 2'b01; x1 = 100; y1 = 150; p1State = 0; x2 = 600; y2 = 600;
        frame();
        req_chk("p1_sprite_hit", 100, 150, 'hFFE0);
        req_chk("p1_sprite_right_edge", 116, 150, 'h5D1F);
        req_chk("p1_sprite_bottom_edge", 100, 182, 'h5D1F);

        x1 = 200;
        req_chk("shadow_holds", 100, 150, 'hFFE0);
        frame();
        req_chk("shadow_updated", 100, 150, 'h5D1F);

        p1health = 5; p2health = 0;
        frame();
        req_chk("p1_bar_last", 23, 0, 'h07E0);
        req_chk("p1_bar_past", 24, 0, 'h5D1F);
        req_chk("p2_bar_zero", 315, 0, 'h5D1F);

        x1 = 100; p1health = 10;
        frame();
        p1health = 9;
        frame();
        for (cnt = 8; cnt >= 0; cnt--) begin
            req_chk("flash", 100, 150, (cnt != 0 && ((cnt / 2) % 2) == 1) ? 'hFFFF : 'hFFE0);
            if (cnt > 0) frame();
        end

        x1 = 2040; y1 = 150;
        frame();
        req_chk("edge_sprite_hit", 2047, 150, 'hFFE0);
        req_chk("edge_sprite_nowrap", 0, 150, 'h5D1F);
        req_chk("edge_sprite_nowrap7", 7, 160, 'h5D1F);

        gameState = 2'b10; x1 = 20; y1 = 100; x2 = 50; y2 = 100; p2health = 20;
        frame();
        nvalid = 0;
        for (int i = 0; i < 10; i++) begin
            pix_req = 1'b1; pix_x = 11'(50 + i); pix_y = 11'(100 + i);
            step();
            if (pix_valid) nvalid++;
        end
        pix_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (pix_valid) nvalid++;
        end
        chk("burst_valid_count", nvalid, 10);
        req_chk("winner_p2_hidden", 55, 110, 'h5D1F);
        req_chk("winner_bars_hidden", 6, 0, 'h5D1F);
        req_chk("winner_p1_drawn", 20, 100, 'hFFE0);

        gameState = 2'b00;
        frame();
        req_chk("title", 30, 30, 'h0010);

        pix_req = 1'b1; pix_x = 5; pix_y = 5;
        step();
        step();
        rst = 1'b0;
        #2;
        chk("midreset_valid", pix_valid, 1'b0);
        pix_req = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        req_chk("post_reset_black", 5, 5, 'h0000);

        for (int f = 0; f < 40; f++) begin
            gameState = 2'($urandom_range(0, 3));
            p1State = 2'($urandom); p2State = 2'($urandom);
            p1health = 5'($urandom); p2health = 5'($urandom);
            x1 = 11'(($urandom_range(0, 9) == 0) ? 2040 : $urandom_range(0, 330));
            y1 = 11'($urandom_range(0, 220));
            x2 = 11'($urandom_range(0, 330));
            y2 = 11'($urandom_range(0, 220));
            frame();
            for (int r = 0; r < 20; r++) begin
                if ($urandom_range(0, 3) == 0) begin
                    x1 = 11'($urandom); p1health = 5'($urandom);
                end
                case ($urandom_range(0, 3))
                    0: begin rx = m_x1 + $urandom_range(0, 20) - 2; ry = m_y1 + $urandom_range(0, 36) - 2; end
                    1: begin rx = m_x2 + $urandom_range(0, 20) - 2; ry = m_y2 + $urandom_range(0, 36) - 2; end
                    2: begin rx = $urandom_range(0, 330); ry = $urandom_range(0, 9); end
                    default: begin rx = $urandom_range(0, 2047); ry = $urandom_range(0, 260); end
                endcase
                pix_req = $urandom_range(0, 4) != 0;
                pix_x = 11'(rx & 2047);
                pix_y = 11'(ry & 2047);
                step();
            end
            pix_req = 1'b0;
        end
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
